cdc_src_fsm: RTL and testbench

Source-side half of the two-phase (toggle) handshake CDC pair, sitting directly upstream of the destination-side receiver in the same CDC channel.
- Accepts items from a valid/ready stream in the source clock domain.
- Launches each item as a held-stable async_data_o with a toggle on async_req_o.
- Waits for the receiver's toggled async_ack_i before launching the next item.
- An optional one-entry skid buffer accepts the next item while one is in flight.

---
 rtl/cdc_pkg.sv | 12 +
 rtl/cdc_sync_bits.sv | 24 ++
 rtl/cdc_src_fsm.sv | 105 ++++++++++
 tb/tb_cdc_src_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types for the two-phase (toggle) handshake CDC pair.
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_src_state_e;

  // Fewer than two flops leaves no settling time for a metastable ack sample.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_sync_bits.sv
// Reset-to-zero flop chain that brings asynchronous level signals into clk_i.
module cdc_sync_bits #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/cdc_src_fsm.sv
// Source side of the toggle-handshake CDC: launches each accepted item as a
// held-stable payload plus a req toggle, then waits for the matching ack toggle.
module cdc_src_fsm
  import cdc_pkg::*;
#(
  parameter type T           = logic,
  parameter int  SYNC_STAGES = 2,
  parameter bit  SKID        = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic async_req_o,
  output T     async_data_o,
  input  logic async_ack_i,
  output logic busy_o
);

  // Upstream handshake: an item moves on a clk_i edge where valid_i && ready_o;
  // ready_o is registered and never depends on valid_i in the same cycle.

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("cdc_src_fsm: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  cdc_src_state_e state_q, state_d;
  logic           buf_vld_q, buf_vld_d;
  T               buf_q, buf_d;
  T               data_d, launch_data;
  logic           req_d, ready_d, launch;
  logic           ack_s, ack_q, ack_evt, acc;

  cdc_sync_bits #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (async_ack_i),
    .q     (ack_s)
  );

  assign ack_evt = ack_s ^ ack_q;
  assign acc     = valid_i && ready_o;

  always_comb begin
    state_d     = state_q;
    buf_vld_d   = buf_vld_q;
    buf_d       = buf_q;
    launch      = 1'b0;
    launch_data = data_i;
    case (state_q)
      IDLE: begin
        // An ack toggle seen here is a protocol violation and is dropped.
        if (acc) launch = 1'b1;
      end
      WAIT_ACK: begin
        if (ack_evt) begin
          if (buf_vld_q) begin
            launch      = 1'b1;
            launch_data = buf_q;
            buf_vld_d   = 1'b0;
          end else if (acc) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (acc && SKID) begin
          buf_d     = data_i;
          buf_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) state_d = WAIT_ACK;
    data_d  = launch ? launch_data : async_data_o;
    req_d   = async_req_o ^ launch;
    ready_d = SKID ? !buf_vld_d : (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      buf_vld_q    <= 1'b0;
      buf_q        <= '0;
      ack_q        <= 1'b0;
      async_req_o  <= 1'b0;
      async_data_o <= '0;
      ready_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_vld_q    <= buf_vld_d;
      buf_q        <= buf_d;
      ack_q        <= ack_s;
      async_req_o  <= req_d;
      async_data_o <= data_d;
      ready_o      <= ready_d;
      busy_o       <= (state_d == WAIT_ACK);
    end
  end

endmodule

// File: tb/tb_cdc_src_fsm.sv
// Bench for cdc_src_fsm: a destination-side receiver model plus directed ack control.
`timescale 1ns/1ps
module tb_cdc_src_fsm;

  logic clk = 1'b0, dst_clk = 1'b0, rst_n = 1'b0;
  real  dst_half = 13.5;

  always #5 clk = ~clk;
  always #(dst_half) dst_clk = ~dst_clk;

  logic [2:0] vld;
  logic [7:0] data_tb;
  logic [2:0] rdy, bsy, req;
  logic [7:0] dout0, dout1, dout2;
  logic       sel, man_mode, ack_man, ack_r;
  logic       ack0, ack1, ack2;
  logic       req_sel, rdy_sel;
  logic [7:0] data_sel;

  int n_chk = 0, n_err = 0, tog_cnt = 0, rx_cnt = 0;
  logic [7:0] exp_q[$];

  // u_main: SKID=1, 2 stages; u_ns: SKID=0; u_s3: SKID=1, 3 stages
  assign ack0 = man_mode ? ack_man : (!sel ? ack_r : 1'b0);
  assign ack1 = ack_man;
  assign ack2 = man_mode ? ack_man : (sel ? ack_r : 1'b0);
  assign req_sel  = sel ? req[2] : req[0];
  assign rdy_sel  = sel ? rdy[2] : rdy[0];
  assign data_sel = sel ? dout2 : dout0;

  cdc_src_fsm #(.T(logic [7:0]), .SYNC_STAGES(2), .SKID(1'b1)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[0]), .ready_o(rdy[0]), .data_i(data_tb),
    .async_req_o(req[0]), .async_data_o(dout0), .async_ack_i(ack0), .busy_o(bsy[0]));

  cdc_src_fsm #(.T(logic [7:0]), .SYNC_STAGES(2), .SKID(1'b0)) u_ns (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[1]), .ready_o(rdy[1]), .data_i(data_tb),
    .async_req_o(req[1]), .async_data_o(dout1), .async_ack_i(ack1), .busy_o(bsy[1]));

  cdc_src_fsm #(.T(logic [7:0]), .SYNC_STAGES(3), .SKID(1'b1)) u_s3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[2]), .ready_o(rdy[2]), .data_i(data_tb),
    .async_req_o(req[2]), .async_data_o(dout2), .async_ack_i(ack2), .busy_o(bsy[2]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Receiver model: sync req, capture payload on each toggle, answer with an ack toggle.
  logic rs1, rs2, rq;
  logic [7:0] rx_exp;
  always @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1 <= 1'b0; rs2 <= 1'b0; rq <= 1'b0; ack_r <= 1'b0;
    end else begin
      rs1 <= req_sel; rs2 <= rs1; rq <= rs2;
      if (rs2 !== rq && !man_mode) begin
        check("rx_item_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          rx_exp = exp_q.pop_front();
          check("rx_data", 32'(data_sel), 32'(rx_exp));
        end
        rx_cnt++;
        ack_r <= ~ack_r;
      end
    end
  end

  // Source-side monitor on the selected DUT.
  logic prev_rst = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = '0;
  bit burst_on = 1'b0, saw_low = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (data_sel !== prev_d) check("data_only_at_launch", 32'(req_sel !== prev_r), 1);
      if (req_sel !== prev_r) tog_cnt++;
      if (burst_on && !rdy_sel) saw_low = 1'b1;
    end
    prev_rst = rst_n; prev_d = data_sel; prev_r = req_sel;
  end

  task automatic do_reset(input logic s, input logic m, input bit chk);
    @(negedge clk);
    rst_n = 1'b0; vld = '0; sel = s; man_mode = m; ack_man = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_ready", 32'(rdy), 0);
      check("rst_req", 32'(req), 0);
      check("rst_busy", 32'(bsy), 0);
      check("rst_data", {8'h0, dout0, dout1, dout2}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (chk) check("ready_after_release", 32'(rdy), 3'b111);
    tog_cnt = 0; rx_cnt = 0;
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge, valid still high.
  task automatic send(input int k, input logic [7:0] d);
    bit done = 1'b0;
    int n = 0;
    vld[k] = 1'b1; data_tb = d;
    while (!done && n < 500) begin
      if (rdy[k]) done = 1'b1;
      @(posedge clk);
      if (done && !man_mode && ((k == 0 && !sel) || (k == 2 && sel))) exp_q.push_back(d);
      @(negedge clk);
      n++;
    end
    check("send_accepted", 32'(done), 1);
  endtask

  task automatic wait_drain(input int k);
    int n = 0;
    while ((exp_q.size() != 0 || bsy[k]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 3000), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat_m, lat_s;
    vld = '0; data_tb = '0; sel = 1'b0; man_mode = 1'b0; ack_man = 1'b0;

    // Single item A5 through the receiver model
    do_reset(1'b0, 1'b0, 1'b1);
    send(0, 8'hA5); vld[0] = 1'b0;
    check("a_req", 32'(req[0]), 1);
    check("a_data", 32'(dout0), 32'hA5);
    check("a_busy", 32'(bsy[0]), 1);
    check("a_ready", 32'(rdy[0]), 1);
    wait_drain(0);
    check("a_busy_fall", 32'(bsy[0]), 0);
    check("a_rx_cnt", rx_cnt, 1);

    // Burst 0..15 with valid held
    tog_cnt = 0; rx_cnt = 0; burst_on = 1'b1; saw_low = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 8'(i));
    vld[0] = 1'b0; burst_on = 1'b0;
    wait_drain(0);
    check("b_toggles", tog_cnt, 16);
    check("b_rx_cnt", rx_cnt, 16);
    check("b_ready_dropped", 32'(saw_low), 1);

    // Reset while busy with a buffered item
    send(0, 8'hE1); send(0, 8'hE2); vld[0] = 1'b0;
    check("f_ready_low", 32'(rdy[0]), 0);
    check("f_busy", 32'(bsy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("f_rst_req", 32'(req[0]), 0);
    check("f_rst_data", 32'(dout0), 0);
    check("f_rst_ready", 32'(rdy[0]), 0);
    check("f_rst_busy", 32'(bsy[0]), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tog_cnt = 0; rx_cnt = 0;
    send(0, 8'h5A); vld[0] = 1'b0;
    check("f_new_data", 32'(dout0), 32'h5A);
    wait_drain(0);
    check("f_rx_cnt", rx_cnt, 1);
    check("f_toggles", tog_cnt, 1);

    // Directed ack control: same-cycle ack + accept, buffered launch
    do_reset(1'b0, 1'b1, 1'b0);
    send(0, 8'h11); vld[0] = 1'b0;
    check("c_req1", 32'(req[0]), 1);
    ack_man = ~ack_man;
    repeat (2) @(negedge clk);
    check("c_busy_hold", 32'(bsy[0]), 1);
    check("c_data_hold", 32'(dout0), 32'h11);
    send(0, 8'h3C); vld[0] = 1'b0;
    check("c_bypass_req", 32'(req[0]), 0);
    check("c_bypass_data", 32'(dout0), 32'h3C);
    check("c_bypass_busy", 32'(bsy[0]), 1);
    send(0, 8'h77); vld[0] = 1'b0;
    check("c_buf_ready", 32'(rdy[0]), 0);
    check("c_buf_data", 32'(dout0), 32'h3C);
    check("c_buf_req", 32'(req[0]), 0);
    ack_man = ~ack_man;
    repeat (2) @(negedge clk);
    check("c_pre_launch_data", 32'(dout0), 32'h3C);
    @(negedge clk);
    check("c_buf_launch_req", 32'(req[0]), 1);
    check("c_buf_launch_data", 32'(dout0), 32'h77);
    check("c_buf_launch_busy", 32'(bsy[0]), 1);
    check("c_buf_launch_ready", 32'(rdy[0]), 1);
    ack_man = ~ack_man;
    repeat (3) @(negedge clk);
    check("c_idle_busy", 32'(bsy[0]), 0);
    check("c_idle_ready", 32'(rdy[0]), 1);
    ack_man = ~ack_man;
    repeat (4) @(negedge clk);
    check("c_spurious_busy", 32'(bsy[0]), 0);
    check("c_spurious_req", 32'(req[0]), 1);

    // SKID=0: ready stays low through WAIT_ACK, second item waits for IDLE
    send(1, 8'h21); data_tb = 8'h22;
    check("d_req1", 32'(req[1]), 1);
    check("d_data1", 32'(dout1), 32'h21);
    check("d_ready_wait", 32'(rdy[1]), 0);
    ack_man = ~ack_man;
    repeat (2) begin
      @(negedge clk);
      check("d_ready_wait_ack", 32'(rdy[1]), 0);
      check("d_data_held", 32'(dout1), 32'h21);
    end
    @(negedge clk);
    check("d_idle_busy", 32'(bsy[1]), 0);
    check("d_idle_ready", 32'(rdy[1]), 1);
    send(1, 8'h22); vld[1] = 1'b0;
    check("d_req2", 32'(req[1]), 0);
    check("d_data2", 32'(dout1), 32'h22);
    check("d_ready2", 32'(rdy[1]), 0);
    ack_man = ~ack_man;
    repeat (3) @(negedge clk);
    check("d_final_busy", 32'(bsy[1]), 0);

    // Ack latency: 3 stages lands one cycle after 2 stages
    repeat (2) @(negedge clk);
    vld[0] = 1'b1; vld[2] = 1'b1; data_tb = 8'h99;
    @(negedge clk);
    vld = '0;
    check("e_busy_main", 32'(bsy[0]), 1);
    check("e_busy_s3", 32'(bsy[2]), 1);
    ack_man = ~ack_man;
    lat_m = 0; lat_s = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (lat_m == 0 && !bsy[0]) lat_m = i;
      if (lat_s == 0 && !bsy[2]) lat_s = i;
    end
    check("e_lat_2stage", lat_m, 3);
    check("e_lat_3stage", lat_s, 4);

    // SYNC_STAGES=3 with random destination clock 0.3x..3x
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      int gap;
      dst_half = real'($urandom_range(167, 17)) / 10.0;
      send(2, 8'($urandom));
      gap = $urandom_range(3, 0);
      if (gap > 0) begin
        vld[2] = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    vld[2] = 1'b0;
    wait_drain(2);
    check("g_toggles", tog_cnt, 20);
    check("g_rx_cnt", rx_cnt, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
